// File: rtl/bram_ctrl_pkg.sv
// Shared types and helpers for the block-RAM port arbiter.
package bram_ctrl_pkg;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  // Width of an index into n items; never below 1 so a 1-bit pointer still exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index; search starts one past the last winner.
module rr_arbiter
  import bram_ctrl_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic                       advance,
  output logic [NREQ-1:0]            grant,
  output logic [clog2(NREQ)-1:0]     grant_idx
);
  localparam int PTR_W = clog2(NREQ);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] idx;
  logic             found;
  int               s;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    s         = 0;
    for (int off = 0; off < NREQ; off++) begin
      s = int'(ptr) + off;
      if (s >= NREQ) s = s - NREQ;
      idx = PTR_W'(s);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // Pointer moves only when someone actually wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (advance)
      ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
  end
endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port block RAM between NREQ requesters: zero-fill after reset,
// then round-robin grants with a one-stage read-response pipeline.
module bram_port_arbiter
  import bram_ctrl_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     ram_w_en,
  output logic                     ram_r_en,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_data_in,
  input  logic [DATA_W-1:0]        ram_data_o,
  output logic                     init_done
);
  localparam int PTR_W = clog2(NREQ);

  state_t                          state;
  logic [ADDR_W:0]                 fill_cnt;
  logic [ADDR_W:0]                 fill_next;
  logic [NREQ-1:0]                 grant;
  logic [NREQ-1:0]                 req_gated;
  logic [NREQ-1:0]                 rd_pend;
  logic [PTR_W-1:0]                gidx;
  logic                            any_grant;
  logic [NREQ-1:0][ADDR_W-1:0]     addr_v;
  logic [NREQ-1:0][DATA_W-1:0]     wdata_v;

  assign addr_v    = req_addr;
  assign wdata_v   = req_wdata;
  assign req_gated = req_valid & {NREQ{state == RUN}};
  assign any_grant = |grant;
  assign req_ready = grant;
  assign fill_next = fill_cnt + {{ADDR_W{1'b0}}, 1'b1};

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_gated),
    .advance   (any_grant),
    .grant     (grant),
    .grant_idx (gidx)
  );

  // RAM-side signals are registered on the grant edge and held through the
  // following cycle, so the RAM's negedge sample sees stable values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      fill_cnt    <= '0;
      init_done   <= 1'b0;
      ram_w_en    <= 1'b0;
      ram_r_en    <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      rd_pend     <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid <= rd_pend;
      if (|rd_pend) rsp_rdata <= ram_data_o;
      rd_pend <= '0;
      case (state)
        INIT: begin
          ram_w_en    <= 1'b1;
          ram_r_en    <= 1'b0;
          ram_addr    <= fill_cnt[ADDR_W-1:0];
          ram_data_in <= '0;
          fill_cnt    <= fill_next;
          // MSB of the next count marks the last word being issued now.
          if (fill_next[ADDR_W]) state <= RUN;
        end
        RUN: begin
          init_done <= 1'b1;
          ram_w_en  <= any_grant & req_we[gidx];
          ram_r_en  <= any_grant & ~req_we[gidx];
          if (any_grant) begin
            ram_addr    <= addr_v[gidx];
            ram_data_in <= wdata_v[gidx];
            rd_pend     <= grant & ~req_we;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule
